// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Four-step fetch/decode/execute/update control unit for a small 4-bit core.
// It drives the PC-select of an external 6-bit program counter, latches the
// instruction word from a synchronous ROM and issues register-file/ALU
// controls. Z/N status flags from the last ALU op steer conditional branches.
//
// Ports
//   clk_main        system clock, rising edge
//   reset           synchronous, active-high
//   stall_i         freezes the sequencer for the cycle it is high
//   pc_i            current program counter
//   instr_data_i    ROM read data (valid one cycle after imem_addr_o)
//   rf_a_data_i     register-file port A read data
//   alu_zero_i      ALU result is zero
//   alu_neg_i       ALU result bit 3
//   imem_addr_o     ROM address (copy of pc_i)
//   ps_o            PC select: 00 hold, 01 +1, 10 +offset+1, 11 +A
//   offset_o        branch offset, ir[3:0]
//   a_val_o         jump amount, rf_a_data_i
//   ir_o            instruction register
//   rf_a_addr_o     ir[7:4]
//   rf_b_addr_o     ir[3:0]
//   rf_dest_o       ir[11:8]
//   rf_we_o         register-file write enable
//   alu_op_o        ir[15:12]
//   halted_o        high while in HALT
//   illegal_o       sticky flag, set by a reserved opcode
// -----------------------------------------------------------------------------
module instr_sequencer (
   input  logic        clk_main,
   input  logic        reset,
   input  logic        stall_i,
   input  logic [5:0]  pc_i,
   input  logic [15:0] instr_data_i,
   input  logic [3:0]  rf_a_data_i,
   input  logic        alu_zero_i,
   input  logic        alu_neg_i,
   output logic [5:0]  imem_addr_o,
   output logic [1:0]  ps_o,
   output logic [3:0]  offset_o,
   output logic [3:0]  a_val_o,
   output logic [15:0] ir_o,
   output logic [3:0]  rf_a_addr_o,
   output logic [3:0]  rf_b_addr_o,
   output logic [3:0]  rf_dest_o,
   output logic        rf_we_o,
   output logic [3:0]  alu_op_o,
   output logic        halted_o,
   output logic        illegal_o
);

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_UPDATE  = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   state_t      state_q;
   logic [15:0] ir_q;
   logic        z_q;
   logic        n_q;
   logic        illegal_q;
   logic        halted_q;

   logic [3:0]  op_s;
   logic        is_alu_s;
   logic        is_rsvd_s;
   logic [1:0]  ps_s;
   logic        rf_we_s;

   assign op_s      = ir_q[15:12];
   assign is_alu_s  = (op_s >= 4'h1) && (op_s <= 4'h7);
   assign is_rsvd_s = (op_s >= 4'hC) && (op_s <= 4'hE);

   // PC-select and write-enable decode; suppressed while reset or stall is high
   always_comb begin
      ps_s    = 2'b00;
      rf_we_s = 1'b0;
      if (reset || stall_i) begin
         ps_s    = 2'b00;
         rf_we_s = 1'b0;
      end else begin
         case (state_q)
            ST_EXECUTE: rf_we_s = is_alu_s;
            ST_UPDATE: begin
               case (op_s)
                  4'h8:    ps_s = z_q ? 2'b10 : 2'b01;  // BZ
                  4'h9:    ps_s = n_q ? 2'b10 : 2'b01;  // BN
                  4'hA:    ps_s = 2'b11;                // JMP
                  4'hB:    ps_s = 2'b10;                // BRA
                  4'hF:    ps_s = 2'b00;                // HALT
                  default: ps_s = 2'b01;                // NOP, ALU ops, reserved
               endcase
            end
            default: begin
               ps_s    = 2'b00;
               rf_we_s = 1'b0;
            end
         endcase
      end
   end

   // Sequencer FSM with instruction register, status flags and sticky status
   always_ff @(posedge clk_main) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         ir_q      <= 16'h0000;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
      end else if (stall_i) begin
         state_q   <= state_q;
         ir_q      <= ir_q;
         z_q       <= z_q;
         n_q       <= n_q;
         illegal_q <= illegal_q;
         halted_q  <= halted_q;
      end else begin
         case (state_q)
            ST_FETCH: state_q <= ST_DECODE;
            ST_DECODE: begin
               ir_q    <= instr_data_i;
               state_q <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (is_alu_s) begin
                  z_q <= alu_zero_i;
                  n_q <= alu_neg_i;
               end else begin
                  z_q <= z_q;
                  n_q <= n_q;
               end
               if (is_rsvd_s) begin
                  illegal_q <= 1'b1;
               end else begin
                  illegal_q <= illegal_q;
               end
               state_q <= ST_UPDATE;
            end
            ST_UPDATE: begin
               if (op_s == 4'hF) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q  <= ST_FETCH;
                  halted_q <= 1'b0;
               end
            end
            ST_HALT: state_q <= ST_HALT;   // left only through reset
            default: state_q <= ST_FETCH;
         endcase
      end
   end

   assign imem_addr_o = pc_i;
   assign ps_o        = ps_s;
   assign rf_we_o     = rf_we_s;
   assign offset_o    = ir_q[3:0];
   assign a_val_o     = rf_a_data_i;
   assign ir_o        = ir_q;
   assign rf_a_addr_o = ir_q[7:4];
   assign rf_b_addr_o = ir_q[3:0];
   assign rf_dest_o   = ir_q[11:8];
   assign alu_op_o    = ir_q[15:12];
   assign halted_o    = halted_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Bench for instr_sequencer. The bench models the program counter, the
// synchronous instruction ROM and a register file whose port A returns
// (address ^ 4'hD). Expected control events (write enables and non-hold PC
// selects, with the cycle they must occur in) are queued before each program
// runs; a monitor pops and compares every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic        clk_main;
   logic        reset;
   logic        stall_i;
   logic [5:0]  pc_q;
   logic [5:0]  pc_start;
   logic [15:0] instr_data_i;
   logic [3:0]  rf_a_data_i;
   logic        alu_zero_i;
   logic        alu_neg_i;
   logic [5:0]  imem_addr_o;
   logic [1:0]  ps_o;
   logic [3:0]  offset_o;
   logic [3:0]  a_val_o;
   logic [15:0] ir_o;
   logic [3:0]  rf_a_addr_o;
   logic [3:0]  rf_b_addr_o;
   logic [3:0]  rf_dest_o;
   logic        rf_we_o;
   logic [3:0]  alu_op_o;
   logic        halted_o;
   logic        illegal_o;

   logic [15:0] rom [64];
   logic [31:0] exp_q [$];
   int          checks;
   int          errors;
   int          cyc;

   instr_sequencer dut (
      .clk_main     (clk_main),
      .reset        (reset),
      .stall_i      (stall_i),
      .pc_i         (pc_q),
      .instr_data_i (instr_data_i),
      .rf_a_data_i  (rf_a_data_i),
      .alu_zero_i   (alu_zero_i),
      .alu_neg_i    (alu_neg_i),
      .imem_addr_o  (imem_addr_o),
      .ps_o         (ps_o),
      .offset_o     (offset_o),
      .a_val_o      (a_val_o),
      .ir_o         (ir_o),
      .rf_a_addr_o  (rf_a_addr_o),
      .rf_b_addr_o  (rf_b_addr_o),
      .rf_dest_o    (rf_dest_o),
      .rf_we_o      (rf_we_o),
      .alu_op_o     (alu_op_o),
      .halted_o     (halted_o),
      .illegal_o    (illegal_o)
   );

   initial begin
      clk_main = 1'b0;
      forever #5 clk_main = ~clk_main;
   end

   assign rf_a_data_i = rf_a_addr_o ^ 4'hD;

   // Program counter model
   always @(posedge clk_main) begin
      if (reset) pc_q <= pc_start;
      else begin
         case (ps_o)
            2'b01:   pc_q <= pc_q + 6'd1;
            2'b10:   pc_q <= pc_q + {2'b00, offset_o} + 6'd1;
            2'b11:   pc_q <= pc_q + {2'b00, a_val_o};
            default: pc_q <= pc_q;
         endcase
      end
   end

   // Synchronous ROM model
   always @(posedge clk_main) instr_data_i <= rom[imem_addr_o];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic check_evt(input logic [31:0] got);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event got=%h expected=none", got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            errors++;
            $display("FAIL event got=%h expected=%h", got, e);
         end
      end
   endtask

   // Event word: {cycle[7:0], we, ps[1:0], 16 field bits, 5'b0}
   task automatic exp_we(input int c, input logic [15:0] ins);
      logic [7:0] c8;
      c8 = c[7:0];
      exp_q.push_back({c8, 3'b100, ins[11:8], ins[7:4], ins[3:0], ins[15:12], 5'd0});
   endtask

   task automatic exp_ps(input int c, input logic [1:0] p, input logic [15:0] ins);
      logic [7:0] c8;
      c8 = c[7:0];
      exp_q.push_back({c8, 1'b0, p, ins[3:0], ins[7:4] ^ 4'hD, 8'd0, 5'd0});
   endtask

   // Monitor: cycle 1 is the first cycle after reset is released
   initial begin
      cyc = 0;
      forever begin
         @(negedge clk_main);
         if (reset) cyc = 0;
         else cyc = cyc + 1;
         if (rf_we_o !== 1'b0)
            check_evt({cyc[7:0], 3'b100, rf_dest_o, rf_a_addr_o, rf_b_addr_o, alu_op_o, 5'd0});
         if (ps_o !== 2'b00)
            check_evt({cyc[7:0], 1'b0, ps_o, offset_o, a_val_o, 8'd0, 5'd0});
      end
   end

   task automatic rom_clear();
      for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
   endtask

   task automatic do_reset(input logic [5:0] start);
      pc_start = start;
      reset    = 1'b1;
      stall_i  = 1'b0;
      repeat (2) @(posedge clk_main);
      #1;
      chk("reset_state", {ps_o, rf_we_o, halted_o, illegal_o, ir_o, imem_addr_o},
          {2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, start});
      reset = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk_main);
      #1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      stall_i    = 1'b0;
      alu_zero_i = 1'b0;
      alu_neg_i  = 1'b0;
      pc_start   = 6'd0;
      rom_clear();

      // ADD at pc 0
      rom[0] = 16'h1123;
      exp_we(3, 16'h1123);
      exp_ps(4, 2'b01, 16'h1123);
      do_reset(6'd0);
      run(4);
      chk("add_next_pc", {26'd0, imem_addr_o}, 32'd1);
      chk("add_ir_held", {16'd0, ir_o}, 32'h0000_1123);

      // SUB sets Z, BZ taken
      rom[0] = 16'h2123; rom[1] = 16'h8005; alu_zero_i = 1'b1;
      exp_we(3, 16'h2123);
      exp_ps(4, 2'b01, 16'h2123);
      exp_ps(8, 2'b10, 16'h8005);
      do_reset(6'd0);
      run(8);
      chk("bz_taken_pc", {26'd0, imem_addr_o}, 32'd7);

      // SUB clears Z, BZ not taken
      alu_zero_i = 1'b0;
      exp_we(3, 16'h2123);
      exp_ps(4, 2'b01, 16'h2123);
      exp_ps(8, 2'b01, 16'h8005);
      do_reset(6'd0);
      run(8);
      chk("bz_not_taken_pc", {26'd0, imem_addr_o}, 32'd2);

      // ADD sets N, BN taken
      rom[0] = 16'h1123; rom[1] = 16'h9002; alu_neg_i = 1'b1;
      exp_we(3, 16'h1123);
      exp_ps(4, 2'b01, 16'h1123);
      exp_ps(8, 2'b10, 16'h9002);
      do_reset(6'd0);
      run(8);
      chk("bn_taken_pc", {26'd0, imem_addr_o}, 32'd4);
      alu_neg_i = 1'b0;

      // JMP at pc 60 by R4 = 9 wraps to 5
      rom_clear();
      rom[60] = 16'hA040;
      exp_ps(4, 2'b11, 16'hA040);
      do_reset(6'd60);
      run(4);
      chk("jmp_wrap_pc", {26'd0, imem_addr_o}, 32'd5);

      // Three-cycle stall in EXECUTE of ADD; flag sampled only when unstalled
      rom_clear();
      rom[0] = 16'h1123; rom[1] = 16'h8005;
      exp_we(6, 16'h1123);
      exp_ps(7, 2'b01, 16'h1123);
      exp_ps(11, 2'b01, 16'h8005);
      do_reset(6'd0);
      run(2);
      stall_i = 1'b1; alu_zero_i = 1'b1;
      run(3);
      stall_i = 1'b0; alu_zero_i = 1'b0;
      run(2);
      chk("stall_7_cycles_pc", {26'd0, imem_addr_o}, 32'd1);
      run(4);
      chk("stall_flag_once_pc", {26'd0, imem_addr_o}, 32'd2);

      // Reserved opcode then HALT
      rom[0] = 16'hD000; rom[1] = 16'hF000;
      exp_ps(4, 2'b01, 16'hD000);
      do_reset(6'd0);
      run(2);
      chk("illegal_before", {31'd0, illegal_o}, 32'd0);
      run(2);
      chk("illegal_set", {31'd0, illegal_o}, 32'd1);
      run(4);
      chk("halted_set", {31'd0, halted_o}, 32'd1);
      run(10);
      chk("halt_sticky", {24'd0, halted_o, illegal_o, imem_addr_o}, {24'd0, 1'b1, 1'b1, 6'd1});

      // Reset during UPDATE of BRA after Z was set
      rom[0] = 16'h1123; rom[1] = 16'hB003; alu_zero_i = 1'b1;
      exp_we(3, 16'h1123);
      exp_ps(4, 2'b01, 16'h1123);
      do_reset(6'd0);
      run(7);
      rom[0] = 16'h8005; alu_zero_i = 1'b0;
      exp_ps(4, 2'b01, 16'h8005);
      do_reset(6'd0);
      run(4);
      chk("flags_cleared_pc", {26'd0, imem_addr_o}, 32'd1);

      run(2);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute control unit that sits upstream of the 6-bit program counter and drives its PC-select (`ps`), branch `offset` and jump `a_val` inputs. It reads 16-bit instruction words from a synchronous instruction ROM addressed by the current PC and issues register-file and ALU controls. It holds Z/N status flags used for conditional branches.

## Interface
- No parameters; all widths fixed: PC 6, instruction 16, register/data 4.
- clk_main  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freezes the sequencer for the cycle in which it is high.
- pc  in  6  current program counter value.
- instr_data  in  16  ROM read data; valid one cycle after `imem_addr`.
- rf_a_data  in  4  register-file port A read data.
- alu_zero  in  1  ALU result == 0.
- alu_neg  in  1  ALU result bit 3.
- imem_addr  out  6  ROM address; combinational copy of `pc`.
- ps  out  2  PC select: 00 hold, 01 +1, 10 +offset+1, 11 +A.
- offset  out  4  branch offset, = `ir[3:0]`.
- a_val  out  4  jump amount, = `rf_a_data`.
- ir  out  16  latched instruction register.
- rf_a_addr, rf_b_addr  out  4 each  = `ir[7:4]`, `ir[3:0]`.
- rf_dest  out  4  = `ir[11:8]`.
- rf_we  out  1  register write enable.
- alu_op  out  4  = `ir[15:12]`.
- halted  out  1  high in HALT state.
- illegal  out  1  sticky; set on reserved opcode.

## Operation
- Instruction format: opcode[15:12], dr[11:8], sa[7:4], sb[3:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 LDI are ALU ops: they write dr and update flags.
  - 8 BZ: branch by sb if Z.
  - 9 BN: branch by sb if N.
  - A JMP: PC += R[sa].
  - B BRA: unconditional branch by sb.
  - C–E reserved: executed as NOP and set `illegal`.
  - F HALT.
- States: FETCH → DECODE → EXECUTE → UPDATE → FETCH; HALT is terminal until reset.
- FETCH: `imem_addr`=`pc`; the ROM registers the address.
- DECODE: `instr_data` is valid; `ir` <= `instr_data` at the end of the cycle.
- EXECUTE:
  - ALU ops: `rf_we`=1; Z <= `alu_zero` and N <= `alu_neg` at the end of the cycle.
  - Reserved opcodes: `illegal` <= 1.
- UPDATE: `ps` is asserted for exactly this cycle:
  - 01 for ALU ops, NOP and reserved opcodes.
  - BZ/BN: 10 if the flag is set, else 01.
  - BRA: 10.
  - JMP: 11.
  - HALT: 00, and next state is HALT instead of FETCH.
- `ps` and `rf_we` are combinational decodes of state, `ir`, flags and `stall`. They are 00/0 in every other state.
- Branch and jump conditions use the flags as they stood at the start of UPDATE, i.e. as set by the most recent ALU op.
- Arithmetic is performed in the PC: `offset` and `a_val` are unsigned and zero-extended, and the PC wraps modulo 64. The sequencer adds nothing itself.
- `stall`=1: state, `ir`, flags and `illegal` hold; `ps`=00 and `rf_we`=0 that cycle. The stalled step completes on the first cycle with `stall`=0.
- Stall in DECODE: the ROM address is unchanged, so data stays valid.

## Timing
- Reset values:
  - state FETCH.
  - `ir`=0, Z=N=0, `illegal`=0, `halted`=0.
  - `ps`=00, `rf_we`=0.
  - `imem_addr` follows `pc`.
- Reset has priority over stall and HALT. Reset asserted mid-instruction aborts it, with no `ps` or `rf_we` issued in the reset cycle.
- 4 cycles per instruction without stalls.
- PC changes on the clock edge ending UPDATE, so the next FETCH sees the new `pc`.
- `ir` is valid from the cycle after DECODE and holds through UPDATE.
- `rf_we` is high for exactly one unstalled EXECUTE cycle per ALU op.
- `halted` goes high in the first HALT cycle; `ps` stays 00 thereafter.

## Test plan
- Reset, then ROM[0]=0x1123 (ADD): `rf_we`=1 with `rf_dest`=1, `rf_a_addr`=2, `rf_b_addr`=3 in cycle 3; `ps`=01 in cycle 4; FETCH again with `pc`=1.
- SUB giving `alu_zero`=1, then BZ sb=5 at pc=1: `ps`=10, `offset`=5 in its UPDATE. With Z=0: `ps`=01.
- JMP with sa=4, `rf_a_data`=9 at pc=60: `ps`=11, `a_val`=9; the PC wraps to 5 with no sequencer error.
- `stall` held for 3 cycles in EXECUTE of an ALU op: `rf_we` low during the stall and high exactly once after; flags update once; total of 7 cycles.
- Opcode 0xD: `illegal` goes to 1 and stays; `ps`=01. Then HALT (0xF000): `halted`=1, `ps`=00 indefinitely; reset clears both.
- Reset asserted in UPDATE of BRA: no `ps`=10 is issued; the sequencer restarts in FETCH with flags cleared.
